// File: rtl/hex_operand_entry_pkg.sv
// Shared constants for the hex operand entry block: phase encodings and debounce defaults.
package hex_operand_entry_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 1000000;
  localparam int CNT_W_DEF           = 20;
  localparam int N_BTN               = 5;

  localparam logic [1:0] PH_ENTER_A = 2'd0;
  localparam logic [1:0] PH_ENTER_B = 2'd1;
  localparam logic [1:0] PH_DONE    = 2'd2;

  // Pulse vector bit positions, ordered by priority (highest index wins).
  localparam int BI_RIGHT = 0;
  localparam int BI_LEFT  = 1;
  localparam int BI_LOAD  = 2;
  localparam int BI_ENTER = 3;
  localparam int BI_CLEAR = 4;

endpackage

// File: rtl/hex_operand_entry_button_debounce.sv
// Raw button -> two-flop sync -> stable-count debounce -> one-cycle press pulse.
// Press pulse appears 2 + DEBOUNCE_CYCLES cycles after a steady raw edge; no backpressure.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_pulse
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_sync1;
  logic             r_sync2;
  logic [1:0]       r_vld;
  logic             r_db;
  logic             r_db_q;
  logic             r_armed;
  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_vld   <= 2'b00;
      r_db    <= 1'b0;
      r_db_q  <= 1'b0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_vld   <= {r_vld[0], 1'b1};
      r_db_q  <= r_db;
      if (r_sync2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_db  <= ~r_db;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
      // A button held through reset must be seen released before it can fire.
      if (r_vld[1] && !r_sync2 && !r_db) begin
        r_armed <= 1'b1;
      end
    end
  end

  assign o_pulse = r_db & ~r_db_q & r_armed;

endmodule

// File: rtl/hex_operand_entry.sv
// Builds two 32-bit divider operands a nibble at a time from switches and debounced buttons.
// Actions take effect one cycle after the debounced pulse; start fires once per committed B.
module hex_operand_entry
  import hex_operand_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int CNT_W           = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  sw,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_load,
  input  logic        btn_enter,
  input  logic        btn_clear,
  output logic [31:0] entry,
  output logic [2:0]  digit_sel,
  output logic [31:0] op_a,
  output logic [31:0] op_b,
  output logic        start,
  output logic [1:0]  phase
);

  logic [N_BTN-1:0] w_raw;
  logic [N_BTN-1:0] w_pulse;

  assign w_raw[BI_RIGHT] = btn_right;
  assign w_raw[BI_LEFT]  = btn_left;
  assign w_raw[BI_LOAD]  = btn_load;
  assign w_raw[BI_ENTER] = btn_enter;
  assign w_raw[BI_CLEAR] = btn_clear;

  for (genvar g = 0; g < N_BTN; g++) begin : g_btn
    button_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_W           (CNT_W)
    ) u_db (
      .clk     (clk),
      .reset   (reset),
      .i_btn   (w_raw[g]),
      .o_pulse (w_pulse[g])
    );
  end

  logic w_do_clear;
  logic w_do_enter;
  logic w_do_load;
  logic w_do_left;
  logic w_do_right;

  assign w_do_clear = w_pulse[BI_CLEAR];
  assign w_do_enter = w_pulse[BI_ENTER] & ~w_pulse[BI_CLEAR];
  assign w_do_load  = w_pulse[BI_LOAD]  & ~(|w_pulse[BI_CLEAR:BI_ENTER]);
  assign w_do_left  = w_pulse[BI_LEFT]  & ~(|w_pulse[BI_CLEAR:BI_LOAD]);
  assign w_do_right = w_pulse[BI_RIGHT] & ~(|w_pulse[BI_CLEAR:BI_LEFT]);

  logic [1:0]  r_state;
  logic [1:0]  w_state_nxt;
  logic [31:0] r_entry;
  logic [31:0] w_entry_nxt;
  logic [2:0]  r_sel;
  logic [2:0]  w_sel_nxt;
  logic [31:0] r_op_a;
  logic [31:0] w_op_a_nxt;
  logic [31:0] r_op_b;
  logic [31:0] w_op_b_nxt;
  logic        r_start;
  logic        w_start_nxt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= PH_ENTER_A;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      PH_ENTER_A: if (w_do_enter) w_state_nxt = PH_ENTER_B;
      PH_ENTER_B: if (w_do_enter) w_state_nxt = PH_DONE;
      PH_DONE:    if (w_do_enter || w_do_clear) w_state_nxt = PH_ENTER_A;
      default:    w_state_nxt = PH_ENTER_A;
    endcase
  end

  always_comb begin
    w_entry_nxt = r_entry;
    w_sel_nxt   = r_sel;
    w_op_a_nxt  = r_op_a;
    w_op_b_nxt  = r_op_b;
    w_start_nxt = 1'b0;
    if (w_do_clear) begin
      w_entry_nxt = '0;
      w_sel_nxt   = '0;
    end else if (w_do_enter) begin
      w_entry_nxt = '0;
      w_sel_nxt   = '0;
      if (r_state == PH_ENTER_A) begin
        w_op_a_nxt = r_entry;
      end else if (r_state == PH_ENTER_B) begin
        w_op_b_nxt  = r_entry;
        w_start_nxt = 1'b1;
      end
    end else if (r_state == PH_ENTER_A || r_state == PH_ENTER_B) begin
      if (w_do_load) begin
        w_entry_nxt[{r_sel, 2'b00} +: 4] = sw;
      end else if (w_do_left) begin
        w_sel_nxt = r_sel + 3'd1;
      end else if (w_do_right) begin
        w_sel_nxt = r_sel - 3'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_entry <= '0;
      r_sel   <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_start <= 1'b0;
    end else begin
      r_entry <= w_entry_nxt;
      r_sel   <= w_sel_nxt;
      r_op_a  <= w_op_a_nxt;
      r_op_b  <= w_op_b_nxt;
      r_start <= w_start_nxt;
    end
  end

  assign entry     = r_entry;
  assign digit_sel = r_sel;
  assign op_a      = r_op_a;
  assign op_b      = r_op_b;
  assign start     = r_start;
  assign phase     = r_state;

endmodule

// File: tb/tb_hex_operand_entry.sv
// Directed bench for hex_operand_entry with a short debounce window.
module tb_hex_operand_entry;

  localparam int DB = 4;
  localparam int CW = 3;

  localparam logic [4:0] B_NONE = 5'b00000;
  localparam logic [4:0] B_R    = 5'b00001;
  localparam logic [4:0] B_L    = 5'b00010;
  localparam logic [4:0] B_LD   = 5'b00100;
  localparam logic [4:0] B_EN   = 5'b01000;
  localparam logic [4:0] B_CLR  = 5'b10000;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  sw;
  logic [4:0]  r_btn;
  logic [31:0] entry;
  logic [2:0]  digit_sel;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        start;
  logic [1:0]  phase;

  always #5 clk = ~clk;

  hex_operand_entry #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (CW)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sw        (sw),
    .btn_left  (r_btn[1]),
    .btn_right (r_btn[0]),
    .btn_load  (r_btn[2]),
    .btn_enter (r_btn[3]),
    .btn_clear (r_btn[4]),
    .entry     (entry),
    .digit_sel (digit_sel),
    .op_a      (op_a),
    .op_b      (op_b),
    .start     (start),
    .phase     (phase)
  );

  typedef struct {
    logic [4:0]  btn;
    logic [3:0]  sw;
    logic [31:0] e_entry;
    logic [2:0]  e_sel;
    logic [1:0]  e_phase;
    logic [31:0] e_op_a;
    logic [31:0] e_op_b;
  } vec_t;

  vec_t tbl [23];
  int   n_vec = 0;
  int   n_bad = 0;
  int   start_cnt = 0;
  int   start_bad = 0;

  always @(negedge clk) begin
    if (start === 1'b1) begin
      start_cnt++;
      if (phase !== 2'd2) start_bad++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press(input logic [4:0] b, input logic [3:0] s);
    sw    = s;
    r_btn = b;
    tick(10);
    r_btn = B_NONE;
    tick(10);
  endtask

  initial begin
    tbl[0]  = '{B_NONE, 4'h0, 32'h0,        3'd0, 2'd0, 32'h0,        32'h0};
    tbl[1]  = '{B_R,    4'h0, 32'h0,        3'd7, 2'd0, 32'h0,        32'h0};
    tbl[2]  = '{B_L,    4'h0, 32'h0,        3'd0, 2'd0, 32'h0,        32'h0};
    tbl[3]  = '{B_L,    4'h0, 32'h0,        3'd1, 2'd0, 32'h0,        32'h0};
    tbl[4]  = '{B_R,    4'h0, 32'h0,        3'd0, 2'd0, 32'h0,        32'h0};
    tbl[5]  = '{B_R,    4'h0, 32'h0,        3'd7, 2'd0, 32'h0,        32'h0};
    tbl[6]  = '{B_LD,   4'h4, 32'h40000000, 3'd7, 2'd0, 32'h0,        32'h0};
    tbl[7]  = '{B_R,    4'h0, 32'h40000000, 3'd6, 2'd0, 32'h0,        32'h0};
    tbl[8]  = '{B_LD,   4'h0, 32'h40000000, 3'd6, 2'd0, 32'h0,        32'h0};
    tbl[9]  = '{B_EN,   4'h0, 32'h0,        3'd0, 2'd1, 32'h40000000, 32'h0};
    tbl[10] = '{B_R,    4'h0, 32'h0,        3'd7, 2'd1, 32'h40000000, 32'h0};
    tbl[11] = '{B_LD,   4'h3, 32'h30000000, 3'd7, 2'd1, 32'h40000000, 32'h0};
    tbl[12] = '{B_R,    4'h0, 32'h30000000, 3'd6, 2'd1, 32'h40000000, 32'h0};
    tbl[13] = '{B_LD,   4'hF, 32'h3F000000, 3'd6, 2'd1, 32'h40000000, 32'h0};
    tbl[14] = '{B_R,    4'h0, 32'h3F000000, 3'd5, 2'd1, 32'h40000000, 32'h0};
    tbl[15] = '{B_LD,   4'h8, 32'h3F800000, 3'd5, 2'd1, 32'h40000000, 32'h0};
    tbl[16] = '{B_EN,   4'h0, 32'h0,        3'd0, 2'd2, 32'h40000000, 32'h3F800000};
    tbl[17] = '{B_LD,   4'h7, 32'h0,        3'd0, 2'd2, 32'h40000000, 32'h3F800000};
    tbl[18] = '{B_L,    4'h0, 32'h0,        3'd0, 2'd2, 32'h40000000, 32'h3F800000};
    tbl[19] = '{B_EN,   4'h0, 32'h0,        3'd0, 2'd0, 32'h40000000, 32'h3F800000};
    tbl[20] = '{B_EN,   4'h0, 32'h0,        3'd0, 2'd1, 32'h0,        32'h3F800000};
    tbl[21] = '{B_EN,   4'h0, 32'h0,        3'd0, 2'd2, 32'h0,        32'h0};
    tbl[22] = '{B_CLR,  4'h0, 32'h0,        3'd0, 2'd0, 32'h0,        32'h0};

    reset = 1'b1;
    sw    = 4'h0;
    r_btn = B_NONE;
    tick(3);
    chk("rst entry", entry, 32'h0);
    chk("rst sel", 32'(digit_sel), 32'h0);
    chk("rst op_a", op_a, 32'h0);
    chk("rst op_b", op_b, 32'h0);
    chk("rst start", 32'(start), 32'h0);
    chk("rst phase", 32'(phase), 32'h0);
    reset = 1'b0;
    tick(5);

    // Glitch shorter than the window, then a clean press with exact timing.
    sw = 4'h5;
    r_btn = B_LD;
    tick(3);
    r_btn = B_NONE;
    tick(10);
    chk("glitch entry", entry, 32'h0);
    r_btn = B_LD;
    tick(6);
    chk("db early entry", entry, 32'h0);
    tick(1);
    chk("db edge entry", entry, 32'h5);
    tick(3);
    r_btn = B_NONE;
    sw = 4'h9;
    tick(12);
    chk("db release entry", entry, 32'h5);
    press(B_CLR, 4'h0);
    chk("clear entry", entry, 32'h0);

    for (int i = 0; i < 23; i++) begin
      press(tbl[i].btn, tbl[i].sw);
      chk($sformatf("v%0d entry", i), entry, tbl[i].e_entry);
      chk($sformatf("v%0d sel", i), 32'(digit_sel), 32'(tbl[i].e_sel));
      chk($sformatf("v%0d phase", i), 32'(phase), 32'(tbl[i].e_phase));
      chk($sformatf("v%0d op_a", i), op_a, tbl[i].e_op_a);
      chk($sformatf("v%0d op_b", i), op_b, tbl[i].e_op_b);
      if (i == 16) chk("start count after B", start_cnt, 1);
    end
    chk("start count total", start_cnt, 2);
    chk("start outside DONE", start_bad, 0);

    // Build 0x12345678, then coincident pulses resolve by priority.
    for (int i = 0; i < 8; i++) begin
      press(B_LD, 4'(8 - i));
      press(B_L, 4'h0);
    end
    chk("build entry", entry, 32'h12345678);
    chk("build sel", 32'(digit_sel), 32'h0);
    press(B_CLR | B_LD, 4'hF);
    chk("prio clr entry", entry, 32'h0);
    chk("prio clr sel", 32'(digit_sel), 32'h0);
    chk("prio clr phase", 32'(phase), 32'h0);
    press(B_LD | B_L, 4'hA);
    chk("prio ld entry", entry, 32'hA);
    chk("prio ld sel", 32'(digit_sel), 32'h0);
    press(B_CLR, 4'h0);

    // Reset in ENTER_B with enter held across it.
    press(B_R, 4'h0);
    press(B_LD, 4'h4);
    press(B_EN, 4'h0);
    chk("pre-rst phase", 32'(phase), 32'h1);
    chk("pre-rst op_a", op_a, 32'h40000000);
    r_btn = B_EN;
    tick(3);
    reset = 1'b1;
    tick(1);
    chk("mid-rst entry", entry, 32'h0);
    chk("mid-rst sel", 32'(digit_sel), 32'h0);
    chk("mid-rst op_a", op_a, 32'h0);
    chk("mid-rst op_b", op_b, 32'h0);
    chk("mid-rst start", 32'(start), 32'h0);
    chk("mid-rst phase", 32'(phase), 32'h0);
    tick(2);
    reset = 1'b0;
    tick(20);
    chk("held enter phase", 32'(phase), 32'h0);
    r_btn = B_NONE;
    tick(12);
    chk("released phase", 32'(phase), 32'h0);
    press(B_EN, 4'h0);
    chk("repress phase", 32'(phase), 32'h1);
    chk("repress op_a", op_a, 32'h0);
    chk("start total end", start_cnt, 2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
